col_parity_apply: RTL and testbench

//  Consumer of the column-parity memory produced by the column-parity stage of the matrix encoder.

---
 rtl/col_parity_apply_pkg.sv | 20 ++
 rtl/col_parity_apply_if.sv | 25 ++
 rtl/col_parity_mix.sv | 25 ++
 rtl/col_parity_apply.sv | 86 ++++++++
 tb/tb_col_parity_apply.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/col_parity_apply_pkg.sv
// Shared parameters, FSM state type and lane indexing for the theta-apply stage.
package col_parity_apply_pkg;
  localparam int LINE_W = 25;
  localparam int SLICES = 64;
  localparam int CNT_W  = 7;
  localparam int ADDR_W = 6;
  localparam int LANES  = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRELOAD = 2'd1,
    RUN     = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Bit position of lane (x,y) inside a memory line.
  function automatic int lane_idx(input int x, input int y);
    return 5 * y + x;
  endfunction
endpackage

// File: rtl/col_parity_apply_if.sv
// Control handshake plus state/parity memory bus of the theta-apply stage.
interface col_parity_apply_if;
  import col_parity_apply_pkg::*;

  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] state_addr;
  logic [LINE_W-1:0] state_line;
  logic [ADDR_W-1:0] par_addr;
  logic [LINE_W-1:0] par_line;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [LINE_W-1:0] write_value;

  modport master (
    input  start, state_line, par_line,
    output busy, done, state_addr, par_addr, wr_en, wr_addr, write_value
  );

  modport slave (
    output start, state_line, par_line,
    input  busy, done, state_addr, par_addr, wr_en, wr_addr, write_value
  );
endinterface

// File: rtl/col_parity_mix.sv
// Combinational theta mix: each lane gets C[x-1] of this slice and C[x+1] of the previous slice.
module col_parity_mix
  import col_parity_apply_pkg::*;
(
  input  logic [LINE_W-1:0] state_line,
  input  logic [LANES-1:0]  cur_par,
  input  logic [LANES-1:0]  prev_par,
  output logic [LINE_W-1:0] write_value
);

  logic [LANES-1:0] col_term;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_col
      assign col_term[gi] = cur_par[(gi + 4) % 5] ^ prev_par[(gi + 1) % 5];
    end

    for (genvar gy = 0; gy < LANES; gy++) begin : g_row
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign write_value[lane_idx(gi, gy)] = state_line[lane_idx(gi, gy)] ^ col_term[gi];
      end
    end
  endgenerate

endmodule

// File: rtl/col_parity_apply.sv
// Theta-apply pass: walks all slices once per start, rewriting each state line with its column terms.
module col_parity_apply
  import col_parity_apply_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  col_parity_apply_if.master bus
);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [CNT_W-1:0]   cnt_inc;
  logic               co;
  logic [LANES-1:0]   prev_par_reg, prev_par_next;
  logic [LINE_W-1:0]  mix_value;
  logic               unused_par_hi;

  // Carry-out fires when the incremented count reaches SLICES, ending RUN after the last slice.
  assign cnt_inc = cnt_reg + CNT_W'(1);
  assign co      = cnt_inc[CNT_W-1];

  assign unused_par_hi = ^bus.par_line[LINE_W-1:LANES];

  col_parity_mix u_mix (
    .state_line  (bus.state_line),
    .cur_par     (bus.par_line[LANES-1:0]),
    .prev_par    (prev_par_reg),
    .write_value (mix_value)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      prev_par_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      prev_par_reg <= prev_par_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    prev_par_next   = prev_par_reg;
    bus.state_addr  = '0;
    bus.par_addr    = '0;
    bus.wr_addr     = '0;
    bus.wr_en       = 1'b0;
    bus.write_value = '0;
    bus.busy        = 1'b0;
    bus.done        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start) state_next = PRELOAD;
      end
      PRELOAD: begin
        // Slice 0 needs the parity of the last slice, fetched before the walk starts.
        bus.busy      = 1'b1;
        bus.par_addr  = ADDR_W'(SLICES - 1);
        prev_par_next = bus.par_line[LANES-1:0];
        cnt_next      = '0;
        state_next    = RUN;
      end
      RUN: begin
        bus.busy        = 1'b1;
        bus.state_addr  = cnt_reg[ADDR_W-1:0];
        bus.par_addr    = cnt_reg[ADDR_W-1:0];
        bus.wr_addr     = cnt_reg[ADDR_W-1:0];
        bus.wr_en       = 1'b1;
        bus.write_value = mix_value;
        prev_par_next   = bus.par_line[LANES-1:0];
        cnt_next        = cnt_inc;
        if (co) state_next = DONE;
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_col_parity_apply.sv
// Self-checking bench for col_parity_apply: memory models, reference theta model, per-cycle write monitor.
module tb_col_parity_apply;
  import col_parity_apply_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic load;

  always #5 clk = ~clk;

  col_parity_apply_if bus();

  col_parity_apply dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  logic [LINE_W-1:0] state_mem  [SLICES];
  logic [LINE_W-1:0] state_init [SLICES];
  logic [LINE_W-1:0] par_mem    [SLICES];
  logic [LINE_W-1:0] exp_line   [SLICES];
  logic [LINE_W-1:0] wr_log     [SLICES];

  int n_checks = 0;
  int n_fail   = 0;
  int exp_addr = 0;
  int n_writes = 0;
  int n_done   = 0;
  int done_cyc = -1;
  bit mon_en   = 1'b0;

  assign bus.state_line = state_mem[bus.state_addr];
  assign bus.par_line   = par_mem[bus.par_addr];

  // State memory: bulk load from the bench, otherwise DUT write-back at the clock edge.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < SLICES; i++) state_mem[i] <= state_init[i];
    end else if (bus.wr_en) begin
      state_mem[bus.wr_addr] <= bus.write_value;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Theta-apply rule: lane (x,y) flips by C[x-1] of this slice and C[x+1] of the slice below.
  function automatic logic [LINE_W-1:0] ref_line(input logic [LINE_W-1:0] st,
                                                 input logic [LINE_W-1:0] cur,
                                                 input logic [LINE_W-1:0] prev);
    logic [LINE_W-1:0] r;
    logic t;
    r = st;
    for (int x = 0; x < 5; x++) begin
      t = cur[(x + 4) % 5] ^ prev[(x + 1) % 5];
      for (int y = 0; y < 5; y++) r[5 * y + x] = r[5 * y + x] ^ t;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (mon_en && !rst && bus.wr_en) begin
      check("wr_addr", 32'(bus.wr_addr), 32'(exp_addr));
      check("rd_addr", {20'd0, bus.state_addr, bus.par_addr}, {20'd0, 6'(exp_addr), 6'(exp_addr)});
      check("busy_during_write", 32'(bus.busy), 32'd1);
      check("write_value", 32'(bus.write_value), 32'(exp_line[bus.wr_addr]));
      $display("wr z=%0d value=%h", bus.wr_addr, bus.write_value);
      wr_log[bus.wr_addr] = bus.write_value;
      exp_addr++;
      n_writes++;
    end
  end

  task automatic load_state();
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  task automatic run_pass(input int s_a, input int s_b, input int rst_cyc);
    for (int z = 0; z < SLICES; z++)
      exp_line[z] = ref_line(state_mem[z], par_mem[z], par_mem[(z + SLICES - 1) % SLICES]);
    exp_addr = 0;
    n_writes = 0;
    n_done   = 0;
    done_cyc = -1;
    mon_en   = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 75; k++) begin
      @(negedge clk);
      bus.start = (k == s_a) || (k == s_b);
      if (k == 1) begin
        check("preload_par_addr", 32'(bus.par_addr), SLICES - 1);
        check("preload_busy", 32'(bus.busy), 32'd1);
      end
      if (bus.done) begin
        n_done++;
        done_cyc = k;
      end
      if (k == rst_cyc) begin
        #2 rst = 1'b1;
        #1;
        check("abort_wr_en", 32'(bus.wr_en), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("abort_done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        break;
      end
    end
    bus.start = 1'b0;
    mon_en = 1'b0;
    if (rst_cyc > 0) begin
      check("abort_writes", 32'(n_writes), 32'(rst_cyc - 1));
      check("abort_no_done", 32'(n_done), 32'd0);
    end else begin
      check("pass_writes", 32'(n_writes), SLICES);
      check("pass_done_count", 32'(n_done), 32'd1);
      check("pass_done_cycle", 32'(done_cyc), 32'd66);
      check("idle_after_pass", 32'(bus.busy), 32'd0);
    end
    $display("pass end: writes=%0d done=%0d done_cycle=%0d", n_writes, n_done, done_cyc);
  endtask

  initial begin
    rst       = 1'b1;
    load      = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < SLICES; i++) begin
      state_init[i] = '0;
      par_mem[i]    = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("rst_state_addr", 32'(bus.state_addr), 32'd0);
    check("rst_par_addr", 32'(bus.par_addr), 32'd0);
    check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    check("rst_write_value", 32'(bus.write_value), 32'd0);
    rst = 1'b0;

    // 1: zero parity, random state -> lines unchanged
    for (int i = 0; i < SLICES; i++) state_init[i] = LINE_W'($urandom);
    load_state();
    run_pass(-1, -1, 0);
    for (int i = 0; i < SLICES; i += 21) check("zero_par_line", 32'(wr_log[i]), 32'(state_init[i]));

    // 2: only par[63][0], zero state
    for (int i = 0; i < SLICES; i++) state_init[i] = '0;
    load_state();
    par_mem[63] = 25'h1;
    run_pass(-1, -1, 0);
    check("wrap_line0", 32'(wr_log[0]), 32'h1084210);
    check("wrap_line63", 32'(wr_log[63]), 32'h0210842);
    check("wrap_line1", 32'(wr_log[1]), 32'h0);

    // 3: only par[5][2]
    par_mem[63] = '0;
    par_mem[5]  = 25'h4;
    load_state();
    run_pass(-1, -1, 0);
    check("mid_line5", 32'(wr_log[5]), 32'h0842108);
    check("mid_line6", 32'(wr_log[6]), 32'h0210842);
    check("mid_line4", 32'(wr_log[4]), 32'h0);

    // 4: stray starts mid-pass and in DONE are ignored
    for (int i = 0; i < SLICES; i++) begin
      state_init[i] = LINE_W'($urandom);
      par_mem[i]    = LINE_W'($urandom);
    end
    load_state();
    run_pass(10, 66, 0);

    // 5: reset mid-pass, then a clean full pass
    run_pass(-1, -1, 30);
    check("post_abort_idle", 32'(bus.busy), 32'd0);
    run_pass(-1, -1, 0);

    // 6: random state and full-width random parity
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < SLICES; i++) begin
        state_init[i] = LINE_W'($urandom);
        par_mem[i]    = LINE_W'($urandom);
      end
      load_state();
      run_pass(-1, -1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
